// File: rtl/neopix_pkg.sv
// Shared definitions for the WS2812-style bitstream receiver.
// Timing helpers convert nanosecond thresholds into system-clock counts.
package neopix_pkg;

    localparam int PIXEL_W      = 24;
    localparam int T0H_NS       = 400;
    localparam int T1H_NS       = 800;
    localparam int PERIOD_NS    = 1250;
    localparam int LATCH_DEF_NS = 50000;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_e;

    // Clock count for a duration, truncated; sys_clk is rounded down to whole MHz first.
    function automatic int ns_to_clk(input int sys_clk, input int ns);
        return (sys_clk / 1000000) * ns / 1000;
    endfunction

endpackage

// File: rtl/neopix_rx_pulse_meas.sv
// Input synchroniser, edge detection and saturating high/low width counters.
// fall_w_s is the total high width (in clocks) of the pulse ending on fall_s.
module pulse_meas #(
    parameter int HMAX = 50,
    parameter int LMAX = 2500,
    parameter int HW   = 6,
    parameter int LW   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    output logic          rise_s,
    output logic          fall_s,
    output logic [HW-1:0] fall_w_s,
    output logic          latch_hit_s
);

    localparam logic [HW-1:0] HMAX_C = HW'(HMAX);
    localparam logic [LW-1:0] LMAX_C = LW'(LMAX);

    logic          sync1_r;
    logic          sync2_r;
    logic          dly_r;
    logic [HW-1:0] hcnt_r;
    logic [LW-1:0] lcnt_r;

    // Two-flop synchroniser plus delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            dly_r   <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~dly_r;
    assign fall_s = ~sync2_r & dly_r;

    // High counter restarts on rise, low counter on fall; both saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r <= '0;
            lcnt_r <= '0;
        end else begin
            if (rise_s) begin
                hcnt_r <= '0;
            end else if (sync2_r && (hcnt_r != HMAX_C)) begin
                hcnt_r <= hcnt_r + 1'b1;
            end else begin
                hcnt_r <= hcnt_r;
            end
            if (fall_s) begin
                lcnt_r <= '0;
            end else if (!sync2_r && (lcnt_r != LMAX_C)) begin
                lcnt_r <= lcnt_r + 1'b1;
            end else begin
                lcnt_r <= lcnt_r;
            end
        end
    end

    assign fall_w_s    = hcnt_r + 1'b1;
    assign latch_hit_s = (lcnt_r == LMAX_C);

endmodule

// File: rtl/neopix_rx.sv
// Decodes a WS2812-style single-wire bitstream into 24-bit pixels and frame-latch events.
// Used as a loopback checker / strip monitor next to the strip controllers.
module neopix_rx
    import neopix_pkg::*;
#(
    parameter int NUM_LEDS     = 256,
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int MIN_HIGH_NS  = 150,
    parameter int THRESH_NS    = 600,
    parameter int MAX_HIGH_NS  = 1000,
    parameter int LATCH_NS     = 50000,
    localparam int IDX_W       = $clog2(NUM_LEDS)
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 DIN,
    output logic [PIXEL_W-1:0]   PIX_DATA,
    output logic                 PIX_VALID,
    output logic [IDX_W-1:0]     PIX_INDEX,
    output logic                 FRAME_DONE,
    output logic [IDX_W:0]       FRAME_LEN,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int MIN_CLK    = ns_to_clk(SYSTEM_CLOCK, MIN_HIGH_NS);
    localparam int THRESH_CLK = ns_to_clk(SYSTEM_CLOCK, THRESH_NS);
    localparam int MAX_CLK    = ns_to_clk(SYSTEM_CLOCK, MAX_HIGH_NS);
    localparam int LATCH_CLK  = ns_to_clk(SYSTEM_CLOCK, LATCH_NS);
    localparam int HW         = $clog2(MAX_CLK + 2);
    localparam int LW         = $clog2(LATCH_CLK + 1);

    localparam logic [HW-1:0]  MIN_W      = HW'(MIN_CLK);
    localparam logic [HW-1:0]  THRESH_W   = HW'(THRESH_CLK);
    localparam logic [HW-1:0]  MAX_W      = HW'(MAX_CLK);
    localparam logic [IDX_W:0] NUM_LEDS_C = (IDX_W + 1)'(NUM_LEDS);
    localparam logic [4:0]     LAST_BIT   = 5'(PIXEL_W - 1);

    logic          rise_s;
    logic          fall_s;
    logic [HW-1:0] fall_w_s;
    logic          latch_hit_s;
    logic          bad_s;
    logic          bit_s;
    logic          room_s;

    rx_state_e            state_r;
    logic [PIXEL_W-2:0]   shift_r;
    logic [4:0]           bcnt_r;
    logic [IDX_W:0]       pcnt_r;
    logic                 err_r;
    logic                 rise_pend_r;
    logic [PIXEL_W-1:0]   pix_data_r;
    logic                 pix_valid_r;
    logic [IDX_W-1:0]     pix_index_r;
    logic                 frame_done_r;
    logic [IDX_W:0]       frame_len_r;
    logic                 frame_err_r;
    logic                 busy_r;

    pulse_meas #(
        .HMAX (MAX_CLK),
        .LMAX (LATCH_CLK),
        .HW   (HW),
        .LW   (LW)
    ) u_meas (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .din         (DIN),
        .rise_s      (rise_s),
        .fall_s      (fall_s),
        .fall_w_s    (fall_w_s),
        .latch_hit_s (latch_hit_s)
    );

    assign bad_s  = (fall_w_s < MIN_W) | (fall_w_s >= MAX_W);
    assign bit_s  = (fall_w_s >= THRESH_W);
    assign room_s = (pcnt_r < NUM_LEDS_C);

    // Frame state machine with pixel assembly and registered strobes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ARM;
            shift_r      <= '0;
            bcnt_r       <= 5'd0;
            pcnt_r       <= '0;
            err_r        <= 1'b0;
            rise_pend_r  <= 1'b0;
            pix_data_r   <= '0;
            pix_valid_r  <= 1'b0;
            pix_index_r  <= '0;
            frame_done_r <= 1'b0;
            frame_len_r  <= '0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            pix_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ARM: begin
                    if (latch_hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= ARM;
                    end
                end
                IDLE: begin
                    if (rise_s || rise_pend_r) begin
                        state_r     <= HIGH;
                        busy_r      <= 1'b1;
                        rise_pend_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        state_r <= LOW;
                        if (bad_s) begin
                            err_r <= 1'b1;
                        end else if (bcnt_r == LAST_BIT) begin
                            pix_data_r <= {shift_r, bit_s};
                            bcnt_r     <= 5'd0;
                            if (room_s) begin
                                pix_valid_r <= 1'b1;
                                pix_index_r <= pcnt_r[IDX_W-1:0];
                                pcnt_r      <= pcnt_r + 1'b1;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end else begin
                            shift_r <= {shift_r[PIXEL_W-3:0], bit_s};
                            bcnt_r  <= bcnt_r + 5'd1;
                        end
                    end else begin
                        state_r <= HIGH;
                    end
                end
                LOW: begin
                    // Latch takes priority; a coincident rise is replayed from IDLE.
                    if (latch_hit_s) begin
                        frame_done_r <= 1'b1;
                        frame_len_r  <= pcnt_r;
                        frame_err_r  <= err_r | (bcnt_r != 5'd0);
                        pcnt_r       <= '0;
                        bcnt_r       <= 5'd0;
                        err_r        <= 1'b0;
                        busy_r       <= 1'b0;
                        rise_pend_r  <= rise_s;
                        state_r      <= IDLE;
                    end else if (rise_s) begin
                        state_r <= HIGH;
                    end else begin
                        state_r <= LOW;
                    end
                end
                default: begin
                    state_r <= ARM;
                end
            endcase
        end
    end

    assign PIX_DATA   = pix_data_r;
    assign PIX_VALID  = pix_valid_r;
    assign PIX_INDEX  = pix_index_r;
    assign FRAME_DONE = frame_done_r;
    assign FRAME_LEN  = frame_len_r;
    assign FRAME_ERR  = frame_err_r;
    assign BUSY       = busy_r;

endmodule

// File: tb/tb_neopix_rx.sv
// Directed bench for neopix_rx: a default-size receiver and a 4-pixel one share the same line.
module tb_neopix_rx;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;
    logic DIN     = 1'b0;

    logic [23:0] pix_data;
    logic        pix_valid;
    logic [7:0]  pix_index;
    logic        frame_done;
    logic [8:0]  frame_len;
    logic        frame_err;
    logic        busy;

    logic [23:0] pix_data4;
    logic        pix_valid4;
    logic [1:0]  pix_index4;
    logic        frame_done4;
    logic [2:0]  frame_len4;
    logic        frame_err4;
    logic        busy4;

    neopix_rx dut (
        .CLK(CLK), .RESET_N(RESET_N), .DIN(DIN),
        .PIX_DATA(pix_data), .PIX_VALID(pix_valid), .PIX_INDEX(pix_index),
        .FRAME_DONE(frame_done), .FRAME_LEN(frame_len), .FRAME_ERR(frame_err), .BUSY(busy)
    );

    neopix_rx #(.NUM_LEDS(4)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .DIN(DIN),
        .PIX_DATA(pix_data4), .PIX_VALID(pix_valid4), .PIX_INDEX(pix_index4),
        .FRAME_DONE(frame_done4), .FRAME_LEN(frame_len4), .FRAME_ERR(frame_err4), .BUSY(busy4)
    );

    always #10 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [23:0] pix_q[$];
    int          idx_q[$];
    int          nvalid    = 0;
    int          nframe    = 0;
    int          last_len  = 0;
    logic        last_err  = 1'b0;
    int          nvalid4   = 0;
    int          last_len4 = 0;
    logic        last_err4 = 1'b0;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (pix_valid === 1'b1) begin
            pix_q.push_back(pix_data);
            idx_q.push_back(int'(pix_index));
            nvalid <= nvalid + 1;
        end
        if (frame_done === 1'b1) begin
            nframe   <= nframe + 1;
            last_len <= int'(frame_len);
            last_err <= frame_err;
        end
        if (pix_valid4 === 1'b1) begin
            nvalid4 <= nvalid4 + 1;
        end
        if (frame_done4 === 1'b1) begin
            last_len4 <= int'(frame_len4);
            last_err4 <= frame_err4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pulse(input int h, input int l);
        DIN = 1'b1;
        repeat (h) @(negedge CLK);
        DIN = 1'b0;
        repeat (l) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_pulse(40, 22);
        else   send_pulse(20, 42);
    endtask

    task automatic send_pixel(input logic [23:0] px);
        @(negedge CLK);
        for (int i = 23; i >= 0; i--) send_bit(px[i]);
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 4000; i++) begin
            if (nframe >= target) break;
            @(posedge CLK);
        end
        chk("frame_seen", nframe, target);
        @(posedge CLK);
    endtask

    task automatic chk_pix(input string tag, input logic [23:0] exp_d, input int exp_i);
        logic [23:0] d;
        int          i;
        if (pix_q.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            d = pix_q.pop_front();
            i = idx_q.pop_front();
            chk({tag, "_data"}, d, exp_d);
            chk({tag, "_index"}, i, exp_i);
        end
    endtask

    task automatic chk_frame(input string tag, input int exp_len, input logic exp_err);
        chk({tag, "_len"}, last_len, exp_len);
        chk({tag, "_err"}, last_err, exp_err);
        chk({tag, "_busy_clear"}, busy, 32'd0);
    endtask

    initial begin
        logic [23:0] px;
        int          nv4_before;

        // Reset state
        repeat (5) @(posedge CLK);
        #1;
        chk("rst_pix_data", pix_data, 32'd0);
        chk("rst_pix_valid", pix_valid, 32'd0);
        chk("rst_pix_index", pix_index, 32'd0);
        chk("rst_frame_done", frame_done, 32'd0);
        chk("rst_frame_len", frame_len, 32'd0);
        chk("rst_frame_err", frame_err, 32'd0);
        chk("rst_busy", busy, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2600) @(negedge CLK);

        // Startup pixel
        send_pixel(24'hFF00A5);
        wait_frames(1);
        chk_pix("start", 24'hFF00A5, 0);
        chk_frame("start", 1, 1'b0);
        chk("start_hold", pix_data, 32'h00FF00A5);
        repeat (3000) @(posedge CLK);
        chk("start_once", nframe, 32'd1);

        // Three pixels back-to-back
        send_pixel(24'h000001);
        chk("three_busy0", busy, 32'd1);
        send_pixel(24'h800000);
        chk("three_busy1", busy, 32'd1);
        send_pixel(24'h123456);
        chk("three_busy2", busy, 32'd1);
        wait_frames(2);
        chk_pix("three0", 24'h000001, 0);
        chk_pix("three1", 24'h800000, 1);
        chk_pix("three2", 24'h123456, 2);
        chk_frame("three", 3, 1'b0);

        // Threshold: 29 clk -> 0, 30 clk -> 1
        @(negedge CLK);
        send_pulse(29, 33);
        send_pulse(30, 32);
        for (int i = 0; i < 22; i++) send_bit(1'b0);
        wait_frames(3);
        chk_pix("thresh", 24'h400000, 0);
        chk_frame("thresh", 1, 1'b0);

        // Glitch inserted at bit 3 is dropped
        px = 24'hFF00A5;
        @(negedge CLK);
        for (int i = 23; i >= 0; i--) begin
            if (i == 20) send_pulse(5, 57);
            send_bit(px[i]);
        end
        wait_frames(4);
        chk_pix("glitch", 24'hFF00A5, 0);
        chk_frame("glitch", 1, 1'b1);

        // Over-long high pulse is dropped
        px = 24'h123456;
        @(negedge CLK);
        for (int i = 23; i >= 0; i--) begin
            if (i == 13) send_pulse(60, 20);
            send_bit(px[i]);
        end
        wait_frames(5);
        chk_pix("long", 24'h123456, 0);
        chk_frame("long", 1, 1'b1);

        // Partial pixel
        px = 24'hABC000;
        @(negedge CLK);
        for (int i = 23; i >= 12; i--) send_bit(px[i]);
        wait_frames(6);
        chk("partial_nvalid", nvalid, 32'd7);
        chk_frame("partial", 0, 1'b1);

        // Five pixels: fits the default receiver, overflows the 4-pixel one
        nv4_before = nvalid4;
        send_pixel(24'h111111);
        send_pixel(24'h222222);
        send_pixel(24'h333333);
        send_pixel(24'h444444);
        send_pixel(24'h555555);
        wait_frames(7);
        chk_pix("five0", 24'h111111, 0);
        chk_pix("five1", 24'h222222, 1);
        chk_pix("five2", 24'h333333, 2);
        chk_pix("five3", 24'h444444, 3);
        chk_pix("five4", 24'h555555, 4);
        chk_frame("five", 5, 1'b0);
        chk("ovf_nvalid", nvalid4 - nv4_before, 32'd4);
        chk("ovf_len", last_len4, 32'd4);
        chk("ovf_err", last_err4, 32'd1);
        chk("ovf_data", pix_data4, 32'h00555555);

        // Reset mid-pixel, released while the line is high
        px = 24'hABCDEF;
        @(negedge CLK);
        for (int i = 23; i >= 14; i--) send_bit(px[i]);
        DIN = 1'b1;
        repeat (10) @(negedge CLK);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_data", pix_data, 32'd0);
        RESET_N = 1'b1;
        repeat (30) @(negedge CLK);
        DIN = 1'b0;
        repeat (100) @(negedge CLK);
        send_pixel(24'h0F0F0F);
        repeat (2600) @(negedge CLK);
        chk("arm_no_valid", nvalid, 32'd12);
        chk("arm_no_frame", nframe, 32'd7);
        send_pixel(24'h5A5A5A);
        wait_frames(8);
        chk_pix("after_rst", 24'h5A5A5A, 0);
        chk_frame("after_rst", 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
